// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
//
// Sends one byte to the PS/2 device: it inhibits the clock, raises a
// request-to-send, shifts the 11-bit frame out on device clock falls, checks
// the device acknowledge and reports done or error.
//
// Ports:
//   Clk      in   system clock, all logic on posedge
//   reset    in   asynchronous active-high reset
//   psClk    in   PS/2 clock line read back from the pad (asynchronous)
//   psData   in   PS/2 data line read back from the pad (asynchronous)
//   txData   in   command byte, sampled when txStart is accepted
//   txStart  in   one-cycle request, accepted only while busy=0
//   busy     out  transfer in progress (bus receiver must ignore the lines)
//   done     out  one-cycle pulse: device acknowledged the frame
//   error    out  one-cycle pulse: NACK or timeout
//   psClkOe  out  1 = pad drives psClk low, 0 = Hi-Z
//   psDataOe out  1 = pad drives psData low, 0 = Hi-Z

module ps2_host_tx #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       psClk,
  input  logic       psData,
  input  logic [7:0] txData,
  input  logic       txStart,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       psClkOe,
  output logic       psDataOe
);

  // One counter serves both the inhibit interval and the fall timeout.
  localparam int MAX_CNT = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t        state;
  logic          clk_s1, clk_s2, clk_prev;
  logic          data_s1, data_s2;
  logic          fall;
  logic [9:0]    frame;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] cyc_cnt;
  logic [CW-1:0] cyc_inc;
  logic          timeout_hit;

  assign fall        = clk_prev & ~clk_s2;
  assign cyc_inc     = cyc_cnt + CW'(1);
  assign timeout_hit = (cyc_inc == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      frame    <= '0;
      bit_cnt  <= '0;
      cyc_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      psClkOe  <= 1'b0;
      psDataOe <= 1'b0;
    end else begin
      clk_s1   <= psClk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= psData;
      data_s2  <= data_s1;
      done     <= 1'b0;
      error    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (txStart) begin
            frame   <= {1'b1, ~^txData, txData};
            bit_cnt <= '0;
            cyc_cnt <= '0;
            busy    <= 1'b1;
            psClkOe <= 1'b1;
            state   <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (cyc_cnt == CW'(INHIBIT_CYCLES - 1)) begin
            cyc_cnt  <= '0;
            psDataOe <= 1'b1;   // start bit, while the clock is still held
            state    <= S_REQ;
          end else begin
            cyc_cnt <= cyc_inc;
          end
        end

        default: begin
          // Device-clocked phase: every cycle without a fall counts toward the abort.
          if (fall) cyc_cnt <= '0;
          else      cyc_cnt <= cyc_inc;

          if (!fall && timeout_hit) begin
            psClkOe  <= 1'b0;
            psDataOe <= 1'b0;
            error    <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            case (state)
              S_REQ: begin
                psClkOe <= 1'b0;
                state   <= S_SEND;
              end
              S_SEND: begin
                if (fall) begin
                  // Stop bit is a 1, so the last shift releases the line.
                  psDataOe <= ~frame[0];
                  frame    <= {1'b0, frame[9:1]};
                  bit_cnt  <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd9) state <= S_ACK;
                end
              end
              S_ACK: begin
                if (fall) begin
                  if (data_s2) begin
                    error <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                  end else begin
                    state <= S_WAIT_IDLE;
                  end
                end
              end
              S_WAIT_IDLE: begin
                if (clk_s2 && data_s2) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a PS/2 device model
`timescale 1ns/1ps

module tb_ps2_host_tx;

  localparam int INH = 50;
  localparam int TMO = 1000;

  logic       Clk = 1'b0;
  logic       reset;
  logic       psClk, psData;
  logic [7:0] txData;
  logic       txStart;
  logic       busy, done, error, psClkOe, psDataOe;

  logic dev_clk  = 1'b1;
  logic dev_data = 1'b1;

  // Open-drain bus: either side may pull low.
  assign psClk  = ~psClkOe & dev_clk;
  assign psData = ~psDataOe & dev_data;

  ps2_host_tx #(.CLK_HZ(50_000_000), .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .Clk(Clk), .reset(reset), .psClk(psClk), .psData(psData),
    .txData(txData), .txStart(txStart), .busy(busy), .done(done), .error(error),
    .psClkOe(psClkOe), .psDataOe(psDataOe)
  );

  always #10 Clk = ~Clk;

  typedef struct {
    int          kind;   // 0 ack/done, 1 nack/error, 2 timeout/error
    logic [10:0] bits;
  } exp_t;

  exp_t        exp_q[$];
  logic [10:0] obs_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int exp_done = 0;
  int cyc      = 0;
  int req_cyc  = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference frame in wire order: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Pulse monitor / scoreboard
  exp_t e;
  logic [10:0] o;
  always @(negedge Clk) begin
    if (!reset) begin
      if (done && error) chk("done_and_error", 1, 0);
      if (done || error) begin
        if (done) n_done++;
        chk("busy_at_pulse", busy, 0);
        chk("oe_at_pulse", {psClkOe, psDataOe}, 0);
        chk("pulse_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("pulse_kind_done", done, e.kind == 0);
          if (e.kind == 2) chk("timeout_latency", cyc - req_cyc, TMO);
          else begin
            chk("frame_captured", obs_q.size() != 0, 1);
            if (obs_q.size() != 0) begin
              o = obs_q.pop_front();
              chk("frame_bits", o, e.bits);
            end
          end
        end
      end
    end
  end

  // Inhibit / request timing monitor
  int   clk_run = 0;
  logic prev_coe = 1'b0, prev_doe = 1'b0;
  always @(negedge Clk) begin
    if (reset) begin
      clk_run  = 0;
      prev_coe = 1'b0;
      prev_doe = 1'b0;
    end else begin
      if (psClkOe) clk_run++;
      if (psDataOe && !prev_doe && psClkOe) begin
        chk("req_cycle", clk_run, INH + 1);
        req_cyc = cyc;
      end
      if (!psClkOe && prev_coe) begin
        chk("clk_oe_len", clk_run, INH + 1);
        clk_run = 0;
      end
      prev_coe = psClkOe;
      prev_doe = psDataOe;
    end
  end

  task automatic send(input logic [7:0] b);
    txData  = b;
    txStart = 1'b1;
    chk("idle_before_start", busy, 0);
    @(negedge Clk);
    txStart = 1'b0;
    chk("busy_rise", busy, 1);
  endtask

  task automatic expect_frame(input logic [7:0] b, input int kind);
    exp_t x;
    x.kind = kind;
    x.bits = ref_frame(b);
    exp_q.push_back(x);
    if (kind == 0) exp_done++;
  endtask

  // mode: 0 ack, 1 nack, 2 never clocks, 3 stop after fall 5 (clock left low)
  task automatic device(input int h, input int mode);
    int n;
    logic [10:0] obs;
    n = 0;
    while (!(psDataOe && !psClkOe) && n < INH + 20) begin
      @(negedge Clk);
      n++;
    end
    chk("req_seen", psDataOe && !psClkOe, 1);
    if (mode == 2 || !(psDataOe && !psClkOe)) return;
    for (int i = 0; i < 11; i++) begin
      repeat (h) @(negedge Clk);
      obs[i] = psData;
      if (i == 10) obs_q.push_back(obs);
      dev_clk = 1'b0;
      if (i == 10 && mode == 0) dev_data = 1'b0;
      if (mode == 3 && i == 4) begin
        repeat (5) @(negedge Clk);
        return;
      end
      repeat (h) @(negedge Clk);
      dev_clk = 1'b1;
    end
    repeat (2) @(negedge Clk);
    dev_data = 1'b1;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (busy && n < max) begin
      @(negedge Clk);
      n++;
    end
    chk("wait_idle_bound", busy, 0);
  endtask

  task automatic frame(input logic [7:0] b, input int h, input int mode);
    expect_frame(b, mode);
    send(b);
    device(h, mode);
    wait_idle(TMO + 200);
  endtask

  initial begin
    #1_800_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    reset   = 1'b1;
    txStart = 1'b0;
    txData  = 8'h00;
    repeat (3) @(negedge Clk);
    chk("reset_state", {busy, done, error, psClkOe, psDataOe}, 0);
    reset = 1'b0;
    @(negedge Clk);

    frame(8'hED, 30, 0);
    // Back-to-back: wait_idle returns on the done cycle, send lands on the next.
    frame(8'h07, 25, 0);
    frame(8'h00, 25, 0);
    frame(8'h3C, 30, 1);
    chk("nack_released", {psClkOe, psDataOe, busy}, 0);

    // Timeout with a second txStart during the frame
    expect_frame(8'h5A, 2);
    send(8'h5A);
    device(30, 2);
    repeat (100) @(negedge Clk);
    txData  = 8'h33;
    txStart = 1'b1;
    @(negedge Clk);
    txStart = 1'b0;
    chk("busy_ignores_start", busy, 1);
    wait_idle(TMO + 200);
    repeat (100) @(negedge Clk);
    chk("start_not_queued", busy, 0);

    // Reset after fall 5
    send(8'hA5);
    device(30, 3);
    #3 reset = 1'b1;
    #1 chk("reset_mid_frame", {psClkOe, psDataOe, busy}, 0);
    @(negedge Clk);
    dev_clk = 1'b1;
    repeat (3) @(negedge Clk);
    reset = 1'b0;
    @(negedge Clk);
    frame(8'hFF, 30, 0);

    for (int k = 0; k < 5; k++) begin
      rb = 8'($urandom_range(0, 255));
      frame(rb, int'($urandom_range(20, 40)), (k == 3) ? 1 : 0);
    end

    repeat (20) @(negedge Clk);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("obs_q_empty", obs_q.size(), 0);
    chk("done_count", n_done, exp_done);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
